// File: rtl/adder_vector_sequencer.sv
// adder_vector_sequencer
// Drives a deterministic operand sequence into the CLA-vs-CRA comparison top,
// holds each vector while both adders settle, samples compare, and keeps
// vector/mismatch counts plus a capture of the first failing vector.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start             run request, honoured only in IDLE or DONE
//   compare           1 when the two adder sums agree
//   A, B, cIn         operands driven to the comparison top
//   busy, done        run in progress / run finished
//   vec_count         vectors sampled in the current run
//   err_count         mismatches in the current run (saturating)
//   first_err_*       operands of the first mismatching vector
//
// state  | meaning
// IDLE   | waiting for start after reset
// APPLY  | operands held, settle counter running
// SAMPLE | closing cycle of a vector; compare is sampled at its end
// DONE   | run complete, results and last vector held
module adder_vector_sequencer #(
  parameter int          NUM_VECTORS   = 1000,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [31:0] SEED          = 32'hACE1_2B3D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        compare,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        cIn,
  output logic        busy,
  output logic        done,
  output logic [15:0] vec_count,
  output logic [15:0] err_count,
  output logic        first_err_valid,
  output logic [31:0] first_err_A,
  output logic [31:0] first_err_B,
  output logic        first_err_cIn
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [15:0] LAST_CNT = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] NUM_V    = 16'(NUM_VECTORS);

  state_t      state, state_nxt;
  logic [15:0] settle_cnt;
  logic [31:0] lfsr;
  logic [31:0] lfsr_1, lfsr_2;
  logic [15:0] next_idx;
  logic        start_run;
  logic        settle_end;
  logic        last_vec;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  assign lfsr_1     = lfsr_step(lfsr);
  assign lfsr_2     = lfsr_step(lfsr_1);
  assign next_idx   = vec_count + 16'd1;
  assign start_run  = start && (state == IDLE || state == DONE);
  assign settle_end = (settle_cnt == LAST_CNT);
  assign last_vec   = (next_idx == NUM_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_run) state_nxt = APPLY;
      APPLY:   if (settle_end) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : APPLY;
      DONE:    if (start_run) state_nxt = APPLY;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      APPLY, SAMPLE: busy = 1'b1;
      DONE:          done = 1'b1;
      default:       ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A               <= 32'h0;
      B               <= 32'h0;
      cIn             <= 1'b0;
      vec_count       <= 16'h0;
      err_count       <= 16'h0;
      first_err_valid <= 1'b0;
      first_err_A     <= 32'h0;
      first_err_B     <= 32'h0;
      first_err_cIn   <= 1'b0;
      settle_cnt      <= 16'h0;
      lfsr            <= SEED_EFF;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            A               <= 32'h0;
            B               <= 32'h0;
            cIn             <= 1'b0;
            vec_count       <= 16'h0;
            err_count       <= 16'h0;
            first_err_valid <= 1'b0;
            first_err_A     <= 32'h0;
            first_err_B     <= 32'h0;
            first_err_cIn   <= 1'b0;
            settle_cnt      <= 16'h0;
            lfsr            <= SEED_EFF;
          end
        end
        APPLY: begin
          settle_cnt <= settle_end ? 16'h0 : settle_cnt + 16'd1;
        end
        SAMPLE: begin
          vec_count <= next_idx;
          if (!compare) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_A     <= A;
              first_err_B     <= B;
              first_err_cIn   <= cIn;
            end
          end
          // The final vector stays on the outputs through DONE.
          if (!last_vec) begin
            if (next_idx == 16'd1) begin
              A   <= 32'hFFFF_FFFF;
              B   <= 32'h0;
              cIn <= 1'b1;
            end else if (next_idx == 16'd2) begin
              A   <= 32'hFFFF_FFFF;
              B   <= 32'hFFFF_FFFF;
              cIn <= 1'b1;
            end else begin
              A    <= lfsr_1;
              B    <= lfsr_2;
              cIn  <= lfsr_1[31] ^ lfsr_2[0];
              lfsr <= lfsr_2;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_vector_sequencer.sv
module tb_adder_vector_sequencer;

  localparam int N = 8;
  localparam int S = 4;
  localparam int W = N * (S + 1);
  localparam logic [31:0] SEED = 32'hACE1_2B3D;

  logic        clk, rst, start, compare;
  logic [31:0] A, B, first_err_A, first_err_B;
  logic        cIn, busy, done, first_err_valid, first_err_cIn;
  logic [15:0] vec_count, err_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] ma [N];
  logic [31:0] mb [N];
  logic        mc [N];
  logic [32:0] cur_tr [W];
  logic [32:0] ref_tr [W];

  adder_vector_sequencer #(.NUM_VECTORS(N), .SETTLE_CYCLES(S), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .compare(compare),
    .A(A), .B(B), .cIn(cIn), .busy(busy), .done(done),
    .vec_count(vec_count), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_A(first_err_A),
    .first_err_B(first_err_B), .first_err_cIn(first_err_cIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] galois(input logic [31:0] s);
    galois = (s >> 1) ^ ({32{s[0]}} & 32'h8020_0003);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_A"}, A, 32'h0);
    chk({tag, "_B"}, B, 32'h0);
    chk({tag, "_cIn"}, 32'(cIn), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_vec"}, 32'(vec_count), 32'h0);
    chk({tag, "_err"}, 32'(err_count), 32'h0);
    chk({tag, "_fev"}, 32'(first_err_valid), 32'h0);
    chk({tag, "_feA"}, first_err_A, 32'h0);
    chk({tag, "_feB"}, first_err_B, 32'h0);
    chk({tag, "_fec"}, 32'(first_err_cIn), 32'h0);
  endtask

  // One run: pattern bit i is the compare value while vector i is driven.
  task automatic run(input string tag, input logic [N-1:0] pat,
                     input int pulse_cyc, input int abort_cyc);
    int errs, first, idx, run_err;
    errs = 0;
    first = -1;
    for (int i = 0; i < N; i++)
      if (!pat[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    @(negedge clk);
    start = 1'b1;
    compare = pat[0];
    @(negedge clk);
    start = 1'b0;
    run_err = 0;
    for (int t = 0; t < W; t++) begin
      idx = t / (S + 1);
      if (t > 0 && (t % (S + 1)) == 0 && !pat[idx-1]) run_err++;
      compare = pat[idx];
      start = (t == pulse_cyc);
      if (t == abort_cyc) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset({tag, "_midrst"});
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        return;
      end
      chk({tag, "_A"}, A, ma[idx]);
      chk({tag, "_B"}, B, mb[idx]);
      chk({tag, "_cIn"}, 32'(cIn), 32'(mc[idx]));
      chk({tag, "_busy"}, 32'(busy), 32'h1);
      chk({tag, "_done_lo"}, 32'(done), 32'h0);
      chk({tag, "_vec_run"}, 32'(vec_count), 32'(idx));
      chk({tag, "_err_run"}, 32'(err_count), 32'(run_err));
      cur_tr[t] = {cIn, A ^ {B[15:0], B[31:16]}};
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'h1);
    chk({tag, "_busy_end"}, 32'(busy), 32'h0);
    chk({tag, "_vec"}, 32'(vec_count), 32'(N));
    chk({tag, "_err"}, 32'(err_count), 32'(errs));
    chk({tag, "_fev"}, 32'(first_err_valid), 32'(first >= 0));
    chk({tag, "_feA"}, first_err_A, (first >= 0) ? ma[first] : 32'h0);
    chk({tag, "_feB"}, first_err_B, (first >= 0) ? mb[first] : 32'h0);
    chk({tag, "_fec"}, 32'(first_err_cIn), (first >= 0) ? 32'(mc[first]) : 32'h0);
    chk({tag, "_hold_A"}, A, ma[N-1]);
  endtask

  initial begin
    logic [31:0] s;
    int diffs;
    ma[0] = 32'h0;         mb[0] = 32'h0;         mc[0] = 1'b0;
    ma[1] = 32'hFFFF_FFFF; mb[1] = 32'h0;         mc[1] = 1'b1;
    ma[2] = 32'hFFFF_FFFF; mb[2] = 32'hFFFF_FFFF; mc[2] = 1'b1;
    s = SEED;
    for (int i = 3; i < N; i++) begin
      s = galois(s); ma[i] = s;
      s = galois(s); mb[i] = s;
      mc[i] = ma[i][31] ^ mb[i][0];
    end

    rst = 1'b1;
    start = 1'b0;
    compare = 1'b1;
    #12 chk_reset("por");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_reset("idle");

    run("clean", 8'hFF, -1, -1);
    ref_tr = cur_tr;
    run("allfail", 8'h00, -1, -1);
    run("single", 8'hFB, -1, -1);
    run("busy_start", 8'hFF, 4 * (S + 1) + 1, -1);
    run("abort", 8'hFF, -1, 5 * (S + 1) + 2);
    run("fresh", 8'hFF, -1, -1);
    run("restart", 8'hFF, -1, -1);
    diffs = 0;
    for (int t = 0; t < W; t++) if (cur_tr[t] !== ref_tr[t]) diffs++;
    chk("restart_trace", 32'(diffs), 32'h0);
    repeat (3) run("random", 8'($urandom), -1, -1);

    // start held high in DONE: restart on the very next edge
    @(negedge clk);
    start = 1'b1;
    compare = 1'b0;
    @(negedge clk);
    chk("hold_busy", 32'(busy), 32'h1);
    chk("hold_done", 32'(done), 32'h0);
    chk("hold_vec", 32'(vec_count), 32'h0);
    chk("hold_err", 32'(err_count), 32'h0);
    chk("hold_A", A, 32'h0);
    start = 1'b0;
    #3 rst = 1'b1;
    #1 chk_reset("final_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_vector_sequencer.md
# adder_vector_sequencer

Self-running stimulus/collection stage for the CLA-vs-CRA adder comparison top. It drives the `A`, `B` and `cIn` operands of the comparison top and holds each vector long enough for both adders to settle. It then samples the top's `compare` result, counts vectors and mismatches, and captures the first failing vector. This replaces free-running random stimulus with a deterministic, reproducible, synthesizable sequence that also runs on hardware.

## Interface
Parameters:
- `NUM_VECTORS`, default 1000: vectors per run; legal range 3..65535.
- `SETTLE_CYCLES`, default 4: cycles each vector is held before `compare` is sampled; must be ≥1.
- `SEED`, default 32'hACE1_2B3D: LFSR load value. A value of 0 is replaced by 32'h1 at elaboration.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: run request, sampled in IDLE or DONE.
- `compare` input 1: result from the comparison top; 1 means the CLA and CRA sums agree.
- `A` output 32: operand A to the comparison top.
- `B` output 32: operand B to the comparison top.
- `cIn` output 1: carry-in to the comparison top.
- `busy` output 1: high in APPLY and SAMPLE.
- `done` output 1: high in DONE.
- `vec_count` output 16: vectors sampled in the current run.
- `err_count` output 16: mismatches in the current run; saturates at 16'hFFFF.
- `first_err_valid` output 1: set when the first mismatch is captured.
- `first_err_A` output 32, `first_err_B` output 32, `first_err_cIn` output 1: operands of the first mismatching vector.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE. Reset enters IDLE.
- IDLE or DONE with `start`=1:
  - Clear `vec_count`, `err_count`, `first_err_*` and the settle counter.
  - Load the LFSR with `SEED`.
  - Drive vector 0 and go to APPLY.
- APPLY: hold operands for `SETTLE_CYCLES` cycles (counter 0..`SETTLE_CYCLES`-1), then go to SAMPLE.
- SAMPLE: register `compare` at the closing edge. At that same edge:
  - Increment `vec_count`.
  - If `compare`=0, increment `err_count` (saturating).
  - If `compare`=0 and `first_err_valid`=0, capture the current `A`/`B`/`cIn` and set `first_err_valid`.
  - If `vec_count`+1 == `NUM_VECTORS`, go to DONE. Otherwise drive the next vector and go to APPLY.
- DONE: outputs hold the last vector and all results. `done` stays high until `start` or `rst`.
- `start` is ignored while `busy`=1.
- Vector order:
  - Vector 0: A=0, B=0, cIn=0.
  - Vector 1: A=32'hFFFF_FFFF, B=0, cIn=1 (full carry propagate).
  - Vector 2: A=32'hFFFF_FFFF, B=32'hFFFF_FFFF, cIn=1.
  - Vector ≥3: the LFSR steps twice per vector. A = state after the first step, B = state after the second step, cIn = A[31]^B[0].
- LFSR: 32-bit Galois, shift right; when the shifted-out bit is 1, XOR with 32'h8020_0003. The LFSR is not stepped for vectors 0..2.
- Restarting from DONE reproduces the identical vector sequence.

## Timing
- Reset values: `A`=0, `B`=0, `cIn`=0, `busy`=0, `done`=0, `vec_count`=0, `err_count`=0, `first_err_valid`=0, `first_err_A`=0, `first_err_B`=0, `first_err_cIn`=0. LFSR is reset to `SEED`.
- `start` seen at edge k: vector 0 is on the outputs and `busy`=1 after edge k.
- Each vector is stable for exactly `SETTLE_CYCLES`+1 cycles. `compare` is sampled at the edge that ends the window, and the next vector appears at that same edge.
- `done` rises, and `busy` falls, after edge k + `NUM_VECTORS`·(`SETTLE_CYCLES`+1).
- Counters and capture registers update at the SAMPLE edge and are visible one cycle later, never combinationally from `compare`.
- `rst` mid-run: all outputs return to their reset values immediately, without waiting for a clock edge. No partial results are retained.
- `start` held high continuously from DONE: a new run begins at the first edge in DONE. `done` is high for one cycle, then the restart clears results.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs immediately match the reset values above. Release, hold `start`=0 for 10 cycles → state unchanged.
- Clean run: `NUM_VECTORS`=8, `SETTLE_CYCLES`=4, `compare` tied 1, pulse `start` → `done` after 40 cycles. Result: `vec_count`=8, `err_count`=0, `first_err_valid`=0. Vectors 0..2 are exactly as listed, and vector 3 matches an LFSR golden model.
- All-fail: same parameters, `compare` tied 0 → `err_count`=8, `first_err_valid`=1, `first_err_A`=0, `first_err_B`=0, `first_err_cIn`=0.
- Single fault: `compare`=0 only while vector 2 is driven → `err_count`=1, `first_err_A`=32'hFFFF_FFFF, `first_err_B`=32'hFFFF_FFFF, `first_err_cIn`=1.
- `start` pulsed while `busy`=1, at vector 4 → run timing and results unaffected. `done` still arrives at cycle 40.
- `rst` at vector 5, then a new run → results match a fresh clean run. A restart from DONE yields a bit-identical operand trace.
